// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Constants shared by the fetch stage and its prefetch queue:
//   - FSM state encodings (BOOT, RUN)
//   - PC increment per fetched instruction
//   - instruction field positions decoded for the control unit
//   - saturating 32-bit increment used by the optional perf counters
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    // Fetch FSM state encodings
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC  = 4;

    // Instruction fields consumed by unidadControl
    localparam int unsigned COND_MSB = 31;
    localparam int unsigned COND_LSB = 28;
    localparam int unsigned OP_MSB   = 27;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned OPC_MSB  = 25;
    localparam int unsigned OPC_LSB  = 20;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry in-order FIFO holding fetched {instr, pc} pairs.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (accepted when not full, or full with pop)
//   push_data   entry to enqueue (WIDTH bits)
//   pop         drop the head entry (ignored when empty)
//   flush       discard all entries (wins over push/pop)
//   head_data   current head entry
//   full/empty  occupancy flags
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign head_data = mem[rd_ptr];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // NOTE: non-blocking assignments in clocked logic, so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: storage is reset here only because the head is visible on
            // out_instr/out_pc, which must read zero after reset; a deeper
            // buffer would leave its data array unreset.
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: issues sequential requests to instruction memory, buffers
// in-order responses in a 2-entry prefetch queue and presents the head to the
// decoder. A taken branch redirects the PC, flushes the queue and discards
// every response still in flight.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt    request handshake (req/addr held until gnt)
//   imem_rvalid/imem_rdata         in-order response, >=1 cycle after grant
//   out_valid/out_ready            head-of-queue handshake
//   out_instr/out_pc               head instruction and its address
//   out_condicion/out_operation/out_opcodes   field slices of out_instr
//   branch_taken/branch_target     redirect from unidadControl (selPC)
//   perf_fetch_cnt/perf_flush_cnt  saturating counters, only with FETCH_PERF_EN
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        out_condicion,
    output logic [1:0]        out_operation,
    output logic [5:0]        out_opcodes,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    logic [0:0]         state;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;      // address of the next response kept
    logic [1:0]         outstanding;  // granted requests not yet answered
    logic [1:0]         drop;         // leading responses still to discard
    logic [1:0]         outstanding_next;

    logic               q_full;
    logic               q_empty;
    logic [1:0]         q_level;
    logic [ENTRY_W-1:0] q_head;
    logic               q_push;
    logic               q_pop;

    logic               pop_req;
    logic               fire;
    logic               resp_accept;
    logic               resp_keep;

    assign q_level = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
    assign pop_req = out_valid && out_ready;

    // Entries leaving this cycle free a slot for a request issued this cycle;
    // a response needs at least one cycle, so it cannot overtake the pop.
    assign imem_req  = !rst && (state == RUN) &&
                       (({1'b0, q_level} + {1'b0, outstanding}) < (pop_req ? 3'd3 : 3'd2));
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    // A response only counts while something is in flight, so a stray rvalid
    // right after reset is ignored.
    assign resp_accept = imem_rvalid && (state == RUN) && (outstanding != 2'd0);
    assign resp_keep   = resp_accept && (drop == 2'd0);

    assign q_push = resp_keep && !branch_taken;
    assign q_pop  = pop_req && !branch_taken;

    assign outstanding_next = outstanding + {1'b0, fire} - {1'b0, resp_accept};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 2'd0;
            drop        <= 2'd0;
        end else begin
            state       <= RUN;
            outstanding <= outstanding_next;
            if (branch_taken) begin
                // Everything still in flight after this edge, including a
                // request granted now, belongs to the abandoned path.
                pc      <= branch_target;
                resp_pc <= branch_target;
                drop    <= outstanding_next;
            end else begin
                if (fire) begin
                    pc <= pc + ADDR_W'(PC_INC);
                end
                if (q_push) begin
                    resp_pc <= resp_pc + ADDR_W'(PC_INC);
                end
                if (resp_accept && (drop != 2'd0)) begin
                    drop <= drop - 2'd1;
                end
            end
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (q_pop),
        .flush     (branch_taken),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign out_valid     = !q_empty;
    assign out_instr     = q_head[ENTRY_W-1:ADDR_W];
    assign out_pc        = q_head[ADDR_W-1:0];
    assign out_condicion = out_instr[COND_MSB:COND_LSB];
    assign out_operation = out_instr[OP_MSB:OP_LSB];
    assign out_opcodes   = out_instr[OPC_MSB:OPC_LSB];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (q_push) begin
                perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            end
            if (branch_taken) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage (ADDR_W=32, RESET_PC=0x100). A memory
// model answers requests in order with configurable grant/response rates; the
// expected instruction stream is the sequential address sequence from the last
// reset or redirect, with each word a fixed function of its address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [3:0]  out_condicion;
    logic [1:0]  out_operation;
    logic [5:0]  out_opcodes;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_condicion (out_condicion),
        .out_operation (out_operation),
        .out_opcodes   (out_opcodes),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Memory model state: in-flight requests in grant order
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];
    bit          pend_stale[$];

    int          cyc;
    logic [31:0] exp_pc;
    int          rdy_pct;
    int          gnt_pct;
    int          rv_pct;
    bit          expect_valid;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          prev_br;
    int          model_fetch;
    int          model_flush;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hE281_2005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reset for one cycle, check reset state, then drive a stray rvalid into
    // the BOOT cycle. Returns just before the BOOT-cycle edge.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        out_ready    = 1'b0;
        branch_taken = 1'b0;
        #1;
        check("req_in_reset", imem_req, 1'b0);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("boot_no_req", imem_req, 1'b0);
        pend_addr.delete();
        pend_cyc.delete();
        pend_stale.delete();
        exp_pc      = RST_PC;
        prev_stall  = 1'b0;
        prev_br     = 1'b0;
        model_fetch = 0;
        model_flush = 0;
        cyc         = 2;
    endtask

    // One clock cycle: check the head if it is consumed, drive the memory
    // model and the branch inputs, record any granted request.
    task automatic step(input bit br, input logic [31:0] tgt);
        bit rdy;
        @(negedge clk);
        rdy = ($urandom_range(99) < rdy_pct);
        if (prev_br) check("valid_after_branch", out_valid, 1'b0);
        if (expect_valid) check("throughput_valid", out_valid, 1'b1);
        if (out_valid && rdy && !br) begin
            check("out_pc", out_pc, exp_pc);
            check("out_instr", out_instr, mem_word(exp_pc));
            check("fields", {out_condicion, out_operation, out_opcodes}, mem_word(exp_pc) >> 20);
            exp_pc = exp_pc + 32'd4;
        end
        out_ready     = rdy;
        branch_taken  = br;
        branch_target = tgt;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        if (pend_addr.size() > 0 && pend_cyc[0] < cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            if (!pend_stale[0] && !br) model_fetch++;
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
            void'(pend_stale.pop_front());
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #1;
        if (prev_stall) begin
            check("req_held", imem_req, 1'b1);
            check("addr_held", imem_addr, prev_addr);
        end
        if (imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_cyc.push_back(cyc);
            pend_stale.push_back(1'b0);
        end
        if (br) begin
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            exp_pc = tgt;
            model_flush++;
        end
        prev_stall = imem_req && !imem_gnt && !br;
        prev_addr  = imem_addr;
        prev_br    = br;
        cyc++;
    endtask

    initial begin
        rst           = 1'b1;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        out_ready     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        rdy_pct       = 100;
        gnt_pct       = 100;
        rv_pct        = 100;
        expect_valid  = 1'b0;

        // First fetch at cycle 2, zero-bubble stream with 1-cycle memory
        do_reset();
        step(1'b0, 32'h0);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, RST_PC);
        check("stray_rvalid_ignored", out_valid, 1'b0);
        step(1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("cond_field", out_condicion, 4'hE);
        check("op_field", out_operation, 2'b00);
        check("opc_field", out_opcodes, 6'b101000);
        expect_valid = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        expect_valid = 1'b0;

        // Consumer stall: queue fills, requests stop, stream resumes intact
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        check("stall_req_off", imem_req, 1'b0);
        check("stall_valid", out_valid, 1'b1);
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

        // Grant withheld: second request held at 0x104
        do_reset();
        step(1'b0, 32'h0);
        gnt_pct = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            check("nogrant_req", imem_req, 1'b1);
            check("nogrant_addr", imem_addr, 32'h104);
        end
        gnt_pct = 100;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);

        // Branch to 0x200 with two responses in flight
        rv_pct = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        check("two_outstanding", pend_addr.size(), 2);
        step(1'b1, 32'h200);
        rv_pct = 100;
        for (int i = 0; i < 10 && !out_valid; i++) step(1'b0, 32'h0);
        check("redirect_valid", out_valid, 1'b1);
        check("redirect_pc", out_pc, 32'h200);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);

        // Reset with the queue full, fetch restarts at RESET_PC
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        check("full_before_reset", out_valid, 1'b1);
        do_reset();
        rdy_pct = 100;
        step(1'b0, 32'h0);
        check("restart_addr", imem_addr, RST_PC);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);

        // Random traffic with random redirects, including a wrap at 2^32
        rdy_pct = 70;
        gnt_pct = 70;
        rv_pct  = 60;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) begin
                step(1'b1, ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC));
            end else begin
                step(1'b0, 32'h0);
            end
        end
`ifdef FETCH_PERF_EN
        @(posedge clk);
        #1;
        check("perf_fetch", perf_fetch_cnt, model_fetch);
        check("perf_flush", perf_flush_cnt, model_flush);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
